// File: rtl/nv_nvdla_pdp_rd_rsp_gen.sv
// PDP read-DMA memory-side responder: queues {size, addr} requests, reads atoms from a
// local backing memory and returns them in order, throttled by latency-FIFO credits.
module nv_nvdla_pdp_rd_rsp_gen #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 256,
  parameter int LAT_DEPTH = 64,
  parameter int REQ_DEPTH = 4
) (
  input  logic                                     nvdla_core_clk,
  input  logic                                     nvdla_core_rstn,
  input  logic                                     rd_req_valid,
  output logic                                     rd_req_ready,
  input  logic [ADDR_W+14:0]                       rd_req_pd,
  output logic                                     rd_rsp_valid,
  input  logic                                     rd_rsp_ready,
  output logic [DATA_W-1:0]                        rd_rsp_pd,
  input  logic                                     rd_cdt_lat_fifo_pop,
  output logic                                     mem_rd_en,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]       mem_rd_addr,
  input  logic [DATA_W-1:0]                        mem_rd_data,
  output logic [$clog2(LAT_DEPTH):0]               credit_cnt,
  output logic                                     idle
);
  localparam int OFF = $clog2(DATA_W/8);
  localparam int AW  = ADDR_W - OFF;
  localparam int CW  = $clog2(LAT_DEPTH) + 1;
  localparam int PW  = $clog2(REQ_DEPTH);
  localparam int EW  = 15 + AW;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e            state_q;
  logic [EW-1:0]     q_mem_q [REQ_DEPTH];
  logic [PW:0]       q_wp_q, q_rp_q;
  logic [AW-1:0]     atom_addr_q;
  logic [14:0]       left_q;
  logic [CW-1:0]     credit_q;
  logic              rd_vld_q;
  logic [DATA_W-1:0] ob_mem_q [2];
  logic              ob_wp_q, ob_rp_q;
  logic [1:0]        ob_cnt_q;

  logic          q_empty, q_full, push, q_pop, burst, have_work, rsp_pop, issue, cdt_err;
  logic [EW-1:0] head;
  logic [AW-1:0] cur_addr;
  logic [14:0]   cur_left;
  logic [2:0]    pend;

  // Byte offset within an atom is meaningless to an atom-aligned memory.
  logic unused_lo_bits;
  assign unused_lo_bits = ^rd_req_pd[OFF-1:0];

  assign q_empty = (q_wp_q == q_rp_q);
  assign q_full  = (q_wp_q[PW] != q_rp_q[PW]) && (q_wp_q[PW-1:0] == q_rp_q[PW-1:0]);
  assign head    = q_mem_q[q_rp_q[PW-1:0]];

  assign rd_req_ready = nvdla_core_rstn & ~q_full;
  assign push         = rd_req_valid & rd_req_ready;

  // When idle the queue head is issued directly, so a new burst starts with no bubble
  // after the previous one finishes.
  assign burst     = (state_q == S_BURST);
  assign have_work = burst | ~q_empty;
  assign cur_addr  = burst ? atom_addr_q : head[AW-1:0];
  assign cur_left  = burst ? left_q      : head[EW-1:AW];

  assign rsp_pop = rd_rsp_valid & rd_rsp_ready;
  // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle sustainable.
  assign pend    = {1'b0, ob_cnt_q} + {2'b0, rd_vld_q} - {2'b0, rsp_pop};
  assign issue   = have_work && (credit_q != '0) && (pend < 3'd2);
  assign q_pop   = issue & ~burst;

  assign mem_rd_en   = issue;
  assign mem_rd_addr = cur_addr;

  assign cdt_err    = rd_cdt_lat_fifo_pop && (credit_q == CW'(LAT_DEPTH));
  assign credit_cnt = credit_q;

  assign rd_rsp_valid = (ob_cnt_q != 2'd0);
  assign rd_rsp_pd    = ob_mem_q[ob_rp_q];
  assign idle         = q_empty && !burst && !rd_vld_q && (ob_cnt_q == 2'd0);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      q_wp_q <= '0;
      q_rp_q <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) q_mem_q[i] <= '0;
    end else begin
      if (push) begin
        q_mem_q[q_wp_q[PW-1:0]] <= {rd_req_pd[ADDR_W+14:ADDR_W], rd_req_pd[ADDR_W-1:OFF]};
        q_wp_q <= q_wp_q + (PW+1)'(1);
      end
      if (q_pop) q_rp_q <= q_rp_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= S_IDLE;
      atom_addr_q <= '0;
      left_q      <= '0;
    end else if (issue) begin
      if (cur_left == 15'd0) begin
        state_q <= S_IDLE;
      end else begin
        state_q     <= S_BURST;
        atom_addr_q <= cur_addr + AW'(1);
        left_q      <= cur_left - 15'd1;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      credit_q <= CW'(LAT_DEPTH);
    end else begin
      credit_q <= credit_q - CW'(issue) + CW'(rd_cdt_lat_fifo_pop & ~cdt_err);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_vld_q    <= 1'b0;
      ob_wp_q     <= 1'b0;
      ob_rp_q     <= 1'b0;
      ob_cnt_q    <= 2'd0;
      ob_mem_q[0] <= '0;
      ob_mem_q[1] <= '0;
    end else begin
      rd_vld_q <= issue;
      if (rd_vld_q) begin
        ob_mem_q[ob_wp_q] <= mem_rd_data;
        ob_wp_q           <= ~ob_wp_q;
      end
      if (rsp_pop) ob_rp_q <= ~ob_rp_q;
      ob_cnt_q <= ob_cnt_q + {1'b0, rd_vld_q} - {1'b0, rsp_pop};
    end
  end

  cdt_overflow_a: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !cdt_err);

endmodule

// File: tb/tb_nv_nvdla_pdp_rd_rsp_gen.sv
// Bench for nv_nvdla_pdp_rd_rsp_gen: request table plus hand-written credit, back-pressure
// and reset sequences, with an address/data scoreboard fed at request time.
module tb_nv_nvdla_pdp_rd_rsp_gen;
  localparam int ADDR_W = 64, DATA_W = 256, LAT_DEPTH = 64, REQ_DEPTH = 4;
  localparam int AW = ADDR_W - 5;

  logic              clk = 1'b0, rstn = 1'b0;
  logic              rd_req_valid = 1'b0, rd_req_ready;
  logic [ADDR_W+14:0] rd_req_pd = '0;
  logic              rd_rsp_valid, rd_rsp_ready;
  logic [DATA_W-1:0] rd_rsp_pd;
  logic              pop = 1'b0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [6:0]        credit_cnt;
  logic              idle;

  always #5 clk = ~clk;

  nv_nvdla_pdp_rd_rsp_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_DEPTH(LAT_DEPTH),
                            .REQ_DEPTH(REQ_DEPTH)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_pd(rd_req_pd),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_pd(rd_rsp_pd),
    .rd_cdt_lat_fifo_pop(pop), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .credit_cnt(credit_cnt), .idle(idle));

  function automatic logic [DATA_W-1:0] pat(input logic [AW-1:0] a);
    return {4{5'b0, a}} ^ {8{32'h5A3C96E1}};
  endfunction

  // Backing memory: data one cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail_now(input string nm);
    checks++; errors++;
    $display("FAIL %s", nm);
  endtask

  logic [AW-1:0]     exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [14:0] size);
    logic [AW-1:0] a = addr[ADDR_W-1:5];
    for (int i = 0; i <= int'(size); i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(pat(a));
      a = a + AW'(1);
    end
  endtask

  int rdy_mode = 0;
  initial begin
    rd_rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rd_rsp_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int issued = 0, rsp_total = 0, max_out = 0;
  bit held = 0;
  logic [DATA_W-1:0] held_pd;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      held = 0; issued = rsp_total;
    end else begin
      if (held) begin
        chk("pd_stable", rd_rsp_pd, held_pd);
        chk("valid_held", rd_rsp_valid, 1);
      end
      if (mem_rd_en) begin
        issued++;
        if (exp_addr_q.size() == 0) fail_now("spurious_issue");
        else chk("mem_rd_addr", mem_rd_addr, exp_addr_q.pop_front());
      end
      if (rd_rsp_valid && rd_rsp_ready) begin
        rsp_total++;
        if (exp_data_q.size() == 0) fail_now("spurious_beat");
        else chk("rsp_pd", rd_rsp_pd, exp_data_q.pop_front());
        held = 0;
      end else begin
        held = rd_rsp_valid; held_pd = rd_rsp_pd;
      end
      if (issued - rsp_total > max_out) max_out = issued - rsp_total;
    end
  end

  task automatic send_req(input logic [ADDR_W-1:0] addr, input logic [14:0] size);
    bit acc = 0;
    push_exp(addr, size);
    rd_req_pd = {size, addr}; rd_req_valid = 1'b1;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk); acc = rd_req_ready;
      @(posedge clk); #1;
    end
    rd_req_valid = 1'b0;
    if (!acc) fail_now("req_accept_timeout");
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = idle && (exp_data_q.size() == 0);
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic return_credits(input int n);
    if (n > 0) begin
      pop = 1'b1;
      repeat (n) @(posedge clk);
      #1 pop = 1'b0;
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [14:0]       size;
    bit                rnd;
    int                exp_beats;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int base, lat, consec, iss0;
    logic [14:0] t4_sizes[6];
    tbl[0] = '{64'h1000, 15'd3, 1'b0, 4};
    tbl[1] = '{64'h301F, 15'd5, 1'b1, 6};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 15'd1, 1'b0, 2};
    tbl[3] = '{64'h40, 15'd31, 1'b1, 32};
    tbl[4] = '{64'h0, 15'd0, 1'b0, 1};
    tbl[5] = '{64'h7FF0_0020, 15'd62, 1'b0, 63};
    t4_sizes = '{15'd7, 15'd3, 15'd0, 15'd15, 15'd9, 15'd4};

    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", rd_req_ready, 0);
    chk("rst_rsp_valid", rd_rsp_valid, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_credit", credit_cnt, 64);
    chk("rst_idle", idle, 1);
    rstn = 1'b1; #1;
    chk("post_rst_ready", rd_req_ready, 1);

    // Single request: latency and credit charge.
    send_req(64'h1000, 15'd3);
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); lat++;
      if (rd_rsp_valid) break;
    end
    chk("first_rsp_latency", lat, 3);
    wait_drain();
    chk("t1_credit", credit_cnt, 60);
    return_credits(4);
    chk("t1_credit_back", credit_cnt, 64);

    // Back-to-back bursts: four beats on consecutive cycles.
    send_req(64'h2000, 15'd1);
    send_req(64'h2040, 15'd1);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rd_rsp_valid) break;
    end
    consec = rd_rsp_valid ? 1 : 0;
    repeat (3) begin @(negedge clk); if (rd_rsp_valid) consec++; end
    chk("b2b_consecutive", consec, 4);
    wait_drain();
    return_credits(4);

    foreach (tbl[i]) begin
      rdy_mode = tbl[i].rnd ? 1 : 0;
      base = rsp_total;
      send_req(tbl[i].addr, tbl[i].size);
      wait_drain();
      rdy_mode = 0;
      chk($sformatf("vec%0d_beats", i), rsp_total - base, tbl[i].exp_beats);
      chk($sformatf("vec%0d_credit", i), credit_cnt, 64 - tbl[i].exp_beats);
      return_credits(tbl[i].exp_beats);
      chk($sformatf("vec%0d_credit_back", i), credit_cnt, 64);
    end

    // Credit exhaustion, single-credit release, pop+issue net zero.
    base = rsp_total;
    send_req(64'h10000, 15'd99);
    repeat (100) @(posedge clk); #1;
    chk("t3_stall_beats", rsp_total - base, 64);
    chk("t3_stall_credit", credit_cnt, 0);
    chk("t3_stall_not_idle", idle, 0);
    pop = 1'b1; @(posedge clk); #1 pop = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("t3_one_more_beat", rsp_total - base, 65);
    pop = 1'b1; @(posedge clk); #1;
    iss0 = issued;
    @(posedge clk); #1;
    chk("t3_pop_issue_net0", credit_cnt, 1);
    chk("t3_pop_issue_issued", issued - iss0, 1);
    repeat (33) @(posedge clk);
    #1 pop = 1'b0;
    wait_drain();
    chk("t3_total_beats", rsp_total - base, 100);
    chk("t3_credit_end", credit_cnt, 0);
    return_credits(64);
    chk("t3_credit_back", credit_cnt, 64);

    // Random back-pressure with the request queue filling up.
    max_out = 0;
    base = rsp_total;
    rdy_mode = 1;
    foreach (t4_sizes[i]) send_req(64'h20000 + 64'(i) * 64'h1000, t4_sizes[i]);
    wait_drain();
    rdy_mode = 0;
    chk("t4_beats", rsp_total - base, 44);
    chk("t4_max_buffered_le2", max_out <= 2, 1);
    return_credits(44);
    chk("t4_credit_back", credit_cnt, 64);

    // Reset in the middle of a burst.
    base = rsp_total;
    send_req(64'h8000, 15'd20);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rsp_total - base >= 7) break;
    end
    #2 rstn = 1'b0;
    #1;
    chk("t6_rsp_valid", rd_rsp_valid, 0);
    chk("t6_credit", credit_cnt, 64);
    chk("t6_idle", idle, 1);
    chk("t6_mem_rd_en", mem_rd_en, 0);
    chk("t6_req_ready", rd_req_ready, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    #1;
    chk("t6_post_credit", credit_cnt, 64);
    chk("t6_post_idle", idle, 1);
    base = rsp_total;
    send_req(64'h500, 15'd2);
    wait_drain();
    chk("t6_recover_beats", rsp_total - base, 3);
    return_credits(3);
    chk("t6_recover_credit", credit_cnt, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
